// File: rtl/poly_tone_gen_if.sv
// Amplifier-side bundle for poly_tone_gen: per-voice note/octave codes in,
// speaker pins (AIN/GAIN/NC/ACTIVE) and per-voice activity flags out.
interface poly_tone_gen_if #(
    parameter int VOICES = 4
);
    logic [3*VOICES-1:0] note;
    logic [3*VOICES-1:0] octave;
    logic                AIN;
    logic                GAIN;
    logic                NC;
    logic                ACTIVE;
    logic [VOICES-1:0]   voice_active;

    modport master (
        output note,
        output octave,
        input  AIN,
        input  GAIN,
        input  NC,
        input  ACTIVE,
        input  voice_active
    );

    modport slave (
        input  note,
        input  octave,
        output AIN,
        output GAIN,
        output NC,
        output ACTIVE,
        output voice_active
    );
endinterface

// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave tone generator with a first-order sigma-delta mixer.
// Define POLY_TONE_RELEASE_EN to build the per-voice release tail after key-up.
module poly_tone_gen #(
    parameter int VOICES      = 4,
    parameter int CNT_W       = 24,
    parameter int RELEASE_CYC = 10_000_000
) (
    input  logic            clk_100M,
    input  logic            rst_n,
    poly_tone_gen_if.slave  bus
);

    localparam int ACC_W = $clog2(VOICES) + 2;
`ifdef POLY_TONE_RELEASE_EN
    localparam int REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
`endif

    generate
        if (CNT_W < 21) begin : g_cnt_w_check
            $error("poly_tone_gen: CNT_W must be at least 21");
        end
        if (VOICES < 1 || VOICES > 8) begin : g_voices_check
            $error("poly_tone_gen: VOICES must be in 1..8");
        end
        if (RELEASE_CYC < 1) begin : g_release_check
            $error("poly_tone_gen: RELEASE_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RELEASE = 2'd2
    } voice_state_t;

    // Half-period for a note code at a given octave, from the 100 MHz C-major table.
    function automatic logic [CNT_W-1:0] hp_lookup(input logic [2:0] code,
                                                    input logic [2:0] oct);
        logic [20:0]      base;
        logic [CNT_W-1:0] base_ext;
        case (code)
            3'd1:    base = 21'd1528902;
            3'd2:    base = 21'd1362097;
            3'd3:    base = 21'd1213491;
            3'd4:    base = 21'd1145383;
            3'd5:    base = 21'd1020420;
            3'd6:    base = 21'd909091;
            3'd7:    base = 21'd809908;
            default: base = 21'd0;
        endcase
        base_ext = CNT_W'(base);
        return base_ext >> oct;
    endfunction

    logic [VOICES-1:0] sq_on;
    logic [VOICES-1:0] voice_on;

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
        voice_state_t     state_reg, state_next;
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic [CNT_W-1:0] hp_cur_reg, hp_cur_next;
        logic [CNT_W-1:0] hp_pend_reg, hp_pend_next;
        logic             sq_reg, sq_next;
        logic [2:0]       note_in;
        logic [2:0]       oct_in;
        logic [CNT_W-1:0] hp_in;
        logic             half_done;
`ifdef POLY_TONE_RELEASE_EN
        logic [REL_W-1:0] rel_reg, rel_next;
`endif

        assign note_in   = bus.note[3*gi +: 3];
        assign oct_in    = bus.octave[3*gi +: 3];
        assign hp_in     = hp_lookup(note_in, oct_in);
        assign half_done = (cnt_reg >= hp_cur_reg);

        always_ff @(posedge clk_100M or negedge rst_n) begin
            if (!rst_n) begin
                state_reg   <= ST_IDLE;
                cnt_reg     <= CNT_W'(1);
                hp_cur_reg  <= '0;
                hp_pend_reg <= '0;
                sq_reg      <= 1'b0;
`ifdef POLY_TONE_RELEASE_EN
                rel_reg     <= '0;
`endif
            end else begin
                state_reg   <= state_next;
                cnt_reg     <= cnt_next;
                hp_cur_reg  <= hp_cur_next;
                hp_pend_reg <= hp_pend_next;
                sq_reg      <= sq_next;
`ifdef POLY_TONE_RELEASE_EN
                rel_reg     <= rel_next;
`endif
            end
        end

        always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            hp_cur_next  = hp_cur_reg;
            hp_pend_next = hp_pend_reg;
            sq_next      = sq_reg;
`ifdef POLY_TONE_RELEASE_EN
            rel_next     = rel_reg;
`endif
            case (state_reg)
                ST_IDLE: begin
                    cnt_next = CNT_W'(1);
                    sq_next  = 1'b0;
                    if (note_in != 3'd0) begin
                        state_next   = ST_PLAY;
                        hp_cur_next  = hp_in;
                        hp_pend_next = hp_in;
                    end
                end
                ST_PLAY: begin
                    // Code 0 has no pitch; keep the last one so a tail sounds right.
                    if (note_in != 3'd0) begin
                        hp_pend_next = hp_in;
                    end
                    if (half_done) begin
                        sq_next     = ~sq_reg;
                        cnt_next    = CNT_W'(1);
                        hp_cur_next = hp_pend_reg;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    if (note_in == 3'd0) begin
`ifdef POLY_TONE_RELEASE_EN
                        state_next = ST_RELEASE;
                        rel_next   = REL_W'(RELEASE_CYC - 1);
`else
                        state_next = ST_IDLE;
                        sq_next    = 1'b0;
                        cnt_next   = CNT_W'(1);
`endif
                    end
                end
`ifdef POLY_TONE_RELEASE_EN
                ST_RELEASE: begin
                    if (half_done) begin
                        sq_next     = ~sq_reg;
                        cnt_next    = CNT_W'(1);
                        hp_cur_next = hp_pend_reg;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    if (note_in != 3'd0) begin
                        state_next   = ST_PLAY;
                        rel_next     = '0;
                        hp_pend_next = hp_in;
                    end else if (rel_reg == '0) begin
                        state_next = ST_IDLE;
                        sq_next    = 1'b0;
                        cnt_next   = CNT_W'(1);
                    end else begin
                        rel_next = rel_reg - REL_W'(1);
                    end
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                    sq_next    = 1'b0;
                    cnt_next   = CNT_W'(1);
                end
            endcase
        end

        assign voice_on[gi] = (state_reg != ST_IDLE);
        assign sq_on[gi]    = sq_reg && (state_reg != ST_IDLE);
    end

    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] t_sum;
    logic [ACC_W-1:0] acc_reg;
    logic             ain_reg;
    logic             active_reg;

    always_comb begin
        sum = '0;
        for (int i = 0; i < VOICES; i++) begin
            sum = sum + ACC_W'(sq_on[i]);
        end
    end

    assign t_sum = acc_reg + sum;

    // First-order sigma-delta: acc never exceeds VOICES-1, so t_sum fits ACC_W.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            ain_reg    <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            if (t_sum >= ACC_W'(VOICES)) begin
                ain_reg <= 1'b1;
                acc_reg <= t_sum - ACC_W'(VOICES);
            end else begin
                ain_reg <= 1'b0;
                acc_reg <= t_sum;
            end
            active_reg <= |voice_on;
        end
    end

    assign bus.AIN          = ain_reg;
    assign bus.ACTIVE       = active_reg;
    assign bus.voice_active = voice_on;
    assign bus.GAIN         = 1'b1;
    assign bus.NC           = 1'b0;

endmodule
